// File: rtl/mem_send_ctrl_pkg.sv
// Shared types for the data-memory issue path: size codes, FSM states,
// and the registered bus request.
package mem_send_ctrl_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } send_state_t;

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [MEM_ADDR_W-1:0] addr;
        logic [3:0]            wstrb;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_send_ctrl_store_lane_fmt.sv
// Combinational request builder: byte strobes, lane-placed write data and
// the bus address/size for one memory access. Also usable by a store buffer.
module mem_send_ctrl_store_lane_fmt
    import mem_send_ctrl_pkg::*;
(
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        unalign_left,
    input  logic        unalign_right,
    input  logic [31:0] addr,
    input  logic [31:0] reg2,
    output mem_req_t    req
);

    logic [1:0] ofs;
    logic       is_left;
    logic       is_right;

    assign ofs      = addr[1:0];
    // Left wins when both flags are set.
    assign is_left  = unalign_left;
    assign is_right = unalign_right && !unalign_left;

    // Build address/size and, for stores, the strobe and lane data.
    always_comb begin
        req.wr    = wr;
        req.size  = size;
        req.addr  = addr;
        req.wstrb = 4'b0000;
        req.wdata = 32'h0;
        if (is_left || is_right) begin
            req.addr = {addr[31:2], 2'b00};
            req.size = SZ_WORD;
        end
        if (wr) begin
            if (is_left) begin
                req.wstrb = 4'b1111 >> (~ofs);
                req.wdata = reg2 >> {~ofs, 3'b000};
            end else if (is_right) begin
                req.wstrb = 4'b1111 << ofs;
                req.wdata = reg2 << {ofs, 3'b000};
            end else begin
                case (size)
                    SZ_BYTE: begin
                        req.wstrb = 4'b0001 << ofs;
                        req.wdata = {4{reg2[7:0]}};
                    end
                    SZ_HALF: begin
                        req.wstrb = addr[1] ? 4'b1100 : 4'b0011;
                        req.wdata = {2{reg2[15:0]}};
                    end
                    SZ_WORD: begin
                        req.wstrb = 4'b1111;
                        req.wdata = reg2;
                    end
                    // Illegal size: still issued so the pipe cannot hang,
                    // but no lane is written.
                    default: begin
                        req.wstrb = 4'b0000;
                        req.wdata = 32'h0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/mem_send_ctrl.sv
// Data-memory issue controller: accepts the MEM-stage access, holds the bus
// request until addr_ok, waits for data_ok and drains flushed accesses.
//
// state   | meaning
// IDLE    | ready for a new access
// REQ     | data_req asserted, waiting for data_addr_ok
// WAIT    | request accepted, waiting for data_data_ok
module mem_send_ctrl
    import mem_send_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic              in_wr,
    input  logic [1:0]        in_size,
    input  logic              in_unalign_left,
    input  logic              in_unalign_right,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_reg2,
    output logic              in_ready,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    output logic              resp_valid,
    output logic              stall
);

    send_state_t state_q;
    send_state_t state_d;
    logic        cancel_q;
    mem_req_t    req_q;
    mem_req_t    req_fmt;
    logic        accept;

    mem_send_ctrl_store_lane_fmt u_fmt (
        .wr            (in_wr),
        .size          (in_size),
        .unalign_left  (in_unalign_left),
        .unalign_right (in_unalign_right),
        .addr          (in_addr),
        .reg2          (in_reg2),
        .req           (req_fmt)
    );

    assign accept = (state_q == ST_IDLE) && in_valid && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        data_req   = 1'b0;
        resp_valid = 1'b0;
        stall      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                stall    = in_valid && !flush;
                if (accept) state_d = ST_REQ;
            end
            ST_REQ: begin
                // Never withdrawn once raised, even when flushed.
                data_req = 1'b1;
                stall    = 1'b1;
                if (data_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                resp_valid = data_data_ok && !cancel_q;
                stall      = !(data_data_ok && !cancel_q);
                if (data_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Cancel flag: remembers a flush that arrived while the access was in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cancel_q <= 1'b0;
        end else if (state_q == ST_WAIT && data_data_ok) begin
            cancel_q <= 1'b0;
        end else if (flush && state_q != ST_IDLE) begin
            cancel_q <= 1'b1;
        end
    end

    // Request registers, loaded with the formatted access on accept.
    always_ff @(posedge clk) begin
        if (!resetn)     req_q <= '0;
        else if (accept) req_q <= req_fmt;
    end

    assign data_wr    = req_q.wr;
    assign data_size  = req_q.size;
    assign data_addr  = req_q.addr;
    assign data_wstrb = req_q.wstrb;
    assign data_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_send_ctrl.sv
module tb_mem_send_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_wr;
    logic [1:0]  in_size;
    logic        in_unalign_left;
    logic        in_unalign_right;
    logic [31:0] in_addr;
    logic [31:0] in_reg2;
    logic        in_ready;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        resp_valid;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_send_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_wr            (in_wr),
        .in_size          (in_size),
        .in_unalign_left  (in_unalign_left),
        .in_unalign_right (in_unalign_right),
        .in_addr          (in_addr),
        .in_reg2          (in_reg2),
        .in_ready         (in_ready),
        .flush            (flush),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_size        (data_size),
        .data_addr        (data_addr),
        .data_wstrb       (data_wstrb),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_data_ok     (data_data_ok),
        .resp_valid       (resp_valid),
        .stall            (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks run 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic ul,
                         input logic ur, input logic [31:0] addr, input logic [31:0] reg2);
        in_valid = 1'b1; in_wr = wr; in_size = size;
        in_unalign_left = ul; in_unalign_right = ur;
        in_addr = addr; in_reg2 = reg2;
        step();
        in_valid = 1'b0; in_wr = 1'b0; in_size = 2'b00;
        in_unalign_left = 1'b0; in_unalign_right = 1'b0;
        in_addr = 32'h0; in_reg2 = 32'h0;
        #1;
    endtask

    task automatic expect_req(input string tag, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [3:0] wstrb,
                              input logic [31:0] wdata);
        chk({tag, "_req"},   32'(data_req),   32'd1);
        chk({tag, "_wr"},    32'(data_wr),    32'(wr));
        chk({tag, "_size"},  32'(data_size),  32'(size));
        chk({tag, "_addr"},  data_addr,       addr);
        chk({tag, "_wstrb"}, 32'(data_wstrb), 32'(wstrb));
        chk({tag, "_wdata"}, data_wdata,      wdata);
    endtask

    // addr_ok now, data_ok on the following cycle.
    task automatic complete(input string tag, input logic exp_resp);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        #1;
        chk({tag, "_resp"}, 32'(resp_valid), 32'(exp_resp));
        step();
        data_data_ok = 1'b0;
        #1;
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, "_req"},   32'(data_req),   32'd0);
        chk({tag, "_wr"},    32'(data_wr),    32'd0);
        chk({tag, "_size"},  32'(data_size),  32'd0);
        chk({tag, "_addr"},  data_addr,       32'd0);
        chk({tag, "_wstrb"}, 32'(data_wstrb), 32'd0);
        chk({tag, "_wdata"}, data_wdata,      32'd0);
        chk({tag, "_resp"},  32'(resp_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready),   32'd1);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_wr = 1'b0; in_size = 2'b00;
        in_unalign_left = 1'b0; in_unalign_right = 1'b0;
        in_addr = 32'h0; in_reg2 = 32'h0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        step(); step();
        #1;
        expect_zero("rst");
        chk("rst_stall", 32'(stall), 32'd0);
        resetn = 1'b1;
        step();

        // SB at offset 3, addr_ok next cycle, data_ok two cycles later.
        in_valid = 1'b1; in_wr = 1'b1; in_size = 2'b00; in_addr = 32'h1003; in_reg2 = 32'h0000_00AB;
        #1;
        chk("sb_stall_idle", 32'(stall), 32'd1);
        chk("sb_ready_idle", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_wr = 1'b0; in_addr = 32'h0; in_reg2 = 32'h0;
        #1;
        expect_req("sb", 1'b1, 2'b00, 32'h1003, 4'b1000, 32'hABAB_ABAB);
        chk("sb_stall_req", 32'(stall), 32'd1);
        chk("sb_ready_req", 32'(in_ready), 32'd0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        #1;
        chk("sb_req_wait", 32'(data_req), 32'd0);
        chk("sb_stall_wait", 32'(stall), 32'd1);
        chk("sb_resp_wait", 32'(resp_valid), 32'd0);
        step();
        data_data_ok = 1'b1;
        #1;
        chk("sb_resp", 32'(resp_valid), 32'd1);
        chk("sb_stall_rel", 32'(stall), 32'd0);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("sb_resp_once", 32'(resp_valid), 32'd0);
        chk("sb_ready_back", 32'(in_ready), 32'd1);

        // SWL at offset 1 and SWR at offset 2.
        issue(1'b1, 2'b10, 1'b1, 1'b0, 32'h4001, 32'h1122_3344);
        expect_req("swl", 1'b1, 2'b10, 32'h4000, 4'b0011, 32'h0000_1122);
        complete("swl", 1'b1);
        issue(1'b1, 2'b10, 1'b0, 1'b1, 32'h4002, 32'h1122_3344);
        expect_req("swr", 1'b1, 2'b10, 32'h4000, 4'b1100, 32'h3344_0000);
        complete("swr", 1'b1);
        // Both unaligned flags: treated as left (offset 2 -> 0111, >>8).
        issue(1'b1, 2'b10, 1'b1, 1'b1, 32'h4006, 32'h1122_3344);
        expect_req("swlr", 1'b1, 2'b10, 32'h4004, 4'b0111, 32'h0011_2233);
        complete("swlr", 1'b1);
        // LWL: word-aligned address, no strobes.
        issue(1'b0, 2'b10, 1'b1, 1'b0, 32'h7003, 32'hFFFF_FFFF);
        expect_req("lwl", 1'b0, 2'b10, 32'h7000, 4'b0000, 32'h0);
        complete("lwl", 1'b1);

        // SH with addr_ok held off five cycles: request stays stable.
        issue(1'b1, 2'b01, 1'b0, 1'b0, 32'h2002, 32'h0000_BEEF);
        for (int i = 0; i < 5; i++) begin
            expect_req("sh_hold", 1'b1, 2'b01, 32'h2002, 4'b1100, 32'hBEEF_BEEF);
            step();
            #1;
        end
        complete("sh", 1'b1);

        // SB at offset 0 and SH at offset 0.
        issue(1'b1, 2'b00, 1'b0, 1'b0, 32'h1000, 32'h1234_5678);
        expect_req("sb0", 1'b1, 2'b00, 32'h1000, 4'b0001, 32'h7878_7878);
        complete("sb0", 1'b1);
        issue(1'b1, 2'b01, 1'b0, 1'b0, 32'h2000, 32'h1234_5678);
        expect_req("sh0", 1'b1, 2'b01, 32'h2000, 4'b0011, 32'h5678_5678);
        complete("sh0", 1'b1);

        // Illegal size: still issued, no strobes.
        issue(1'b1, 2'b11, 1'b0, 1'b0, 32'h2004, 32'h1234_5678);
        chk("sz3_req", 32'(data_req), 32'd1);
        chk("sz3_wstrb", 32'(data_wstrb), 32'd0);
        complete("sz3", 1'b1);

        // Flush while waiting for data_ok: response suppressed.
        issue(1'b0, 2'b10, 1'b0, 1'b0, 32'h5000, 32'hDEAD_BEEF);
        expect_req("lw5", 1'b0, 2'b10, 32'h5000, 4'b0000, 32'h0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        data_data_ok = 1'b1;
        #1;
        chk("fw_resp", 32'(resp_valid), 32'd0);
        chk("fw_stall", 32'(stall), 32'd1);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("fw_ready", 32'(in_ready), 32'd1);
        chk("fw_req", 32'(data_req), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 1'b0, 32'h3000, 32'h0);
        expect_req("lw3", 1'b0, 2'b10, 32'h3000, 4'b0000, 32'h0);
        complete("lw3", 1'b1);

        // Flush while requesting: request held, cancel honoured at data_ok.
        issue(1'b1, 2'b10, 1'b0, 1'b0, 32'h6000, 32'hCAFE_F00D);
        flush = 1'b1;
        #1;
        chk("fr_req_flush", 32'(data_req), 32'd1);
        step();
        flush = 1'b0;
        #1;
        expect_req("fr_hold", 1'b1, 2'b10, 32'h6000, 4'b1111, 32'hCAFE_F00D);
        step();
        #1;
        chk("fr_req_hold2", 32'(data_req), 32'd1);
        // data_ok while still in REQ is ignored.
        data_data_ok = 1'b1;
        #1;
        chk("fr_early_ok", 32'(resp_valid), 32'd0);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("fr_still_req", 32'(data_req), 32'd1);
        complete("fr", 1'b0);

        // Flush with in_valid in IDLE: nothing issued.
        in_valid = 1'b1; in_wr = 1'b1; in_size = 2'b10; in_addr = 32'h8000; flush = 1'b1;
        #1;
        chk("fi_stall", 32'(stall), 32'd0);
        step();
        in_valid = 1'b0; in_wr = 1'b0; in_addr = 32'h0; flush = 1'b0;
        #1;
        chk("fi_req", 32'(data_req), 32'd0);
        chk("fi_ready", 32'(in_ready), 32'd1);

        // Reset while waiting: everything returns to zero.
        issue(1'b1, 2'b10, 1'b0, 1'b0, 32'h9000, 32'h5555_AAAA);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        expect_zero("rw");
        issue(1'b0, 2'b00, 1'b0, 1'b0, 32'h3001, 32'h0);
        expect_req("post_rst", 1'b0, 2'b00, 32'h3001, 4'b0000, 32'h0);
        complete("post_rst", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
